// File: rtl/uwasic_spi_pkg.sv
// Shared constants for the SPI register peripheral: frame length, register map
// and the frame FSM encoding.
package uwasic_spi_pkg;

   localparam int FRAME_BITS = 16;

   localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
   localparam logic [6:0] ADDR_DUTY      = 7'd4;

   localparam int MAX_ADDR = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } spi_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes one asynchronous pin into the clk domain and reports its level
// together with single-cycle rise/fall pulses that line up with that level.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   cur;

   assign cur   = sync_q[SYNC_STAGES-1];
   assign level = hist_q;

   // Edge pulses are registered so they are valid in the same cycle as the
   // history flop that level presents, keeping all three pins mutually aligned.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         hist_q <= cur;
         rise   <= cur & ~hist_q;
         fall   <= ~cur & hist_q;
      end
   end

endmodule

// File: rtl/spi_reg_peripheral.sv
// Write-only SPI mode-0 target: decodes 16-bit R/W+address+data frames and
// loads the PWM peripheral's control registers.
module spi_reg_peripheral #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = uwasic_spi_pkg::FRAME_BITS,
   parameter int MAX_ADDR    = uwasic_spi_pkg::MAX_ADDR
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe
);
   import uwasic_spi_pkg::*;

   localparam int CNT_W = $clog2(FRAME_BITS + 2);

   logic sclk_level_unused, sclk_rise, sclk_fall_unused;
   logic copi_level, copi_rise_unused, copi_fall_unused;
   logic ncs_level_unused, ncs_rise, ncs_fall;

   spi_state_t            state, state_next;
   logic [CNT_W-1:0]      bit_cnt;
   logic [FRAME_BITS-1:0] shift_q;
   logic                  start_pending;
   logic                  frame_rw;
   logic [6:0]            frame_addr;
   logic [7:0]            frame_data;
   logic                  commit_write;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din(sclk),
      .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .din(copi),
      .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .din(ncs),
      .level(ncs_level_unused), .rise(ncs_rise), .fall(ncs_fall)
   );

   assign frame_rw     = shift_q[FRAME_BITS-1];
   assign frame_addr   = shift_q[14:8];
   assign frame_data   = shift_q[7:0];
   assign commit_write = (state == ST_COMMIT) && frame_rw && (frame_addr <= 7'(MAX_ADDR));

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (ncs_fall || start_pending) state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (ncs_rise)
               state_next = (bit_cnt == CNT_W'(FRAME_BITS)) ? ST_COMMIT : ST_IDLE;
         end
         ST_COMMIT: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // An nCS fall arriving while COMMIT is busy is remembered so the next frame
   // still starts; an sclk rise coinciding with the nCS rise is not shifted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         bit_cnt         <= '0;
         shift_q         <= '0;
         start_pending   <= 1'b0;
         wr_strobe       <= 1'b0;
         en_reg_out_7_0  <= 8'h00;
         en_reg_out_15_8 <= 8'h00;
         en_reg_pwm_7_0  <= 8'h00;
         en_reg_pwm_15_8 <= 8'h00;
         pwm_duty_cycle  <= 8'h00;
      end else begin
         state     <= state_next;
         wr_strobe <= commit_write;

         if (state == ST_IDLE && state_next == ST_SHIFT) begin
            bit_cnt <= '0;
            shift_q <= '0;
         end else if (state == ST_SHIFT && sclk_rise && !ncs_rise) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_level};
            if (bit_cnt <= CNT_W'(FRAME_BITS)) bit_cnt <= bit_cnt + 1'b1;
         end

         if (state == ST_COMMIT && ncs_fall) start_pending <= 1'b1;
         else if (state == ST_IDLE)          start_pending <= 1'b0;

         if (commit_write) begin
            unique case (frame_addr)
               ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
               ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
               ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
               ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
               ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Scoreboard bench for spi_reg_peripheral: directed SPI frames push expected
// writes, a negedge monitor pops them whenever wr_strobe fires.
module tb_spi_reg_peripheral;

   localparam int SYNC_STAGES = 2;
   localparam int HALF_SCLK   = 4;

   logic       clk = 1'b0;
   logic       rst_n, sclk, copi, ncs;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
   logic       wr_strobe;

   typedef struct {
      logic [6:0] addr;
      logic [7:0] data;
      int         rise_cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   spi_reg_peripheral #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] regByAddr(input logic [6:0] a);
      case (a)
         7'd0:    return en_reg_out_7_0;
         7'd1:    return en_reg_out_15_8;
         7'd2:    return en_reg_pwm_7_0;
         7'd3:    return en_reg_pwm_15_8;
         7'd4:    return pwm_duty_cycle;
         default: return 8'hxx;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%02h expected=0x%02h", name, act, exp);
      end
   endtask

   task automatic checkInt(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
      checkOutput({tag, "_en_out_lo"}, en_reg_out_7_0, e0);
      checkOutput({tag, "_en_out_hi"}, en_reg_out_15_8, e1);
      checkOutput({tag, "_en_pwm_lo"}, en_reg_pwm_7_0, e2);
      checkOutput({tag, "_en_pwm_hi"}, en_reg_pwm_15_8, e3);
      checkOutput({tag, "_duty"}, pwm_duty_cycle, e4);
   endtask

   // Every strobe must match the oldest expected write, both in content and in
   // its distance from the nCS rising edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && wr_strobe !== 1'b0) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL spurious_strobe actual=%b expected=0 at cycle %0d", wr_strobe, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("reg_write", regByAddr(mon_e.addr), mon_e.data);
            checkInt("strobe_latency", cyc - mon_e.rise_cyc, SYNC_STAGES + 3);
         end
      end
   end

   // Called at a negedge with nCS high; drives nbits MSB-first at f_clk/8 and
   // returns at a negedge with nCS still low.
   task automatic sendBits(input logic [31:0] frame, input int nbits);
      ncs = 1'b0;
      repeat (HALF_SCLK) @(negedge clk);
      for (int i = nbits - 1; i >= 0; i--) begin
         copi = frame[i];
         repeat (HALF_SCLK) @(negedge clk);
         sclk = 1'b1;
         repeat (HALF_SCLK) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (HALF_SCLK) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [31:0] frame, input int nbits, input int gap);
      logic valid;
      valid = (nbits == 16) && frame[15] && (frame[14:8] <= 7'd4);
      sendBits(frame, nbits);
      if (valid) exp_q.push_back('{addr: frame[14:8], data: frame[7:0], rise_cyc: cyc});
      ncs = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      ncs   = 1'b1;
      sclk  = 1'b0;
      copi  = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      checkAll("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("reset_strobe", {7'd0, wr_strobe}, 8'h00);

      $display("[TB] test 1: write 0x80FF");
      applyStimulus(32'h80FF, 16, 12);
      checkAll("t1", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);

      $display("[TB] test 2: write 0x8480");
      applyStimulus(32'h8480, 16, 12);
      checkAll("t2", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h80);

      $display("[TB] test 3: read frame and out-of-range address");
      applyStimulus(32'h01AA, 16, 12);
      applyStimulus(32'h85AA, 16, 12);
      checkAll("t3", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h80);

      $display("[TB] test 4: 15-bit and 17-bit frames");
      applyStimulus(32'h8255 >> 1, 15, 12);
      applyStimulus(32'h8255 << 1, 17, 12);
      checkAll("t4", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h80);

      $display("[TB] test 5: back-to-back frames");
      applyStimulus(32'h8112, 16, 2);
      applyStimulus(32'h8334, 16, 12);
      checkAll("t5", 8'hFF, 8'h12, 8'h00, 8'h34, 8'h80);

      $display("[TB] test 6: reset mid-frame");
      sendBits(32'h82F0 >> 8, 8);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ncs   = 1'b1;
      repeat (10) @(negedge clk);
      checkAll("t6_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      applyStimulus(32'h82F0, 16, 12);
      checkAll("t6_write", 8'h00, 8'h00, 8'hF0, 8'h00, 8'h00);

      repeat (20) @(negedge clk);
      checkInt("pending_writes", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
